// File: rtl/safe_access_ctrl.sv
// Button-safe access controller: collects a full code entry from three
// active-low buttons, compares it with a programmable code register, and
// drives open / error / lockout timing plus the LED and lock outputs.
module safe_access_ctrl #(
  parameter int unsigned           CODE_LEN     = 4,
  parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE = 8'b10_01_00_00,
  parameter int unsigned           TIME_OPEN    = 250_000_000,
  parameter int unsigned           TIME_ERR     = 150_000_000,
  parameter int unsigned           TIME_LOCK    = 1_500_000_000,
  parameter int unsigned           MAX_FAIL     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn,
  input  logic       prog_en,
  output logic       unlock,
  output logic       lockout,
  output logic [1:0] fail_cnt,
  output logic [7:0] leds_verde,
  output logic       led_vermelho
);

  localparam int unsigned CW   = 2 * CODE_LEN;
  localparam logic [2:0]  LAST = 3'(CODE_LEN - 1);

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_PROG    = 3'd2,
    ST_ERR     = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  state_t          state, state_n;
  logic [2:0]      idx, idx_n;
  logic [CW-1:0]   entry, entry_n, entry_cand;
  logic [CW-1:0]   shadow, shadow_n, shadow_cand;
  logic [CW-1:0]   code, code_n;
  logic [31:0]     timer, timer_n;
  logic [1:0]      fail_n;
  logic [2:0]      btn_prev, btn_pos, btn_edge;
  logic            key_evt;
  logic [1:0]      key_val;

  // n ones from bit 0 upward (n <= 8)
  function automatic logic [7:0] therm(input logic [3:0] n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  // Press detection: a key event is any newly pressed button; more than one
  // at once decodes to 3, which can never equal a stored digit.
  always_comb begin
    btn_pos  = ~btn;
    btn_edge = btn_pos & ~btn_prev;
    key_evt  = |btn_edge;
    case (btn_edge)
      3'b001:  key_val = 2'd0;
      3'b010:  key_val = 2'd1;
      3'b100:  key_val = 2'd2;
      default: key_val = 2'd3;
    endcase
  end

  // Next-state logic; the candidate registers hold the current key value
  // inserted at slot idx so the final digit can be compared in its own cycle.
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    entry_n     = entry;
    shadow_n    = shadow;
    code_n      = code;
    timer_n     = timer;
    fail_n      = fail_cnt;
    entry_cand  = (entry & ~(CW'(3) << (2 * idx))) | (CW'(key_val) << (2 * idx));
    shadow_cand = (shadow & ~(CW'(3) << (2 * idx))) | (CW'(key_val) << (2 * idx));
    case (state)
      ST_ENTRY: begin
        if (key_evt) begin
          entry_n = entry_cand;
          if (idx == LAST) begin
            idx_n = '0;
            if (entry_cand == code) begin
              state_n = ST_OPEN;
              timer_n = TIME_OPEN - 32'd1;
              fail_n  = '0;
            end else if ({30'd0, fail_cnt} + 32'd1 == MAX_FAIL) begin
              state_n = ST_LOCKOUT;
              timer_n = TIME_LOCK - 32'd1;
            end else begin
              state_n = ST_ERR;
              timer_n = TIME_ERR - 32'd1;
              fail_n  = fail_cnt + 2'd1;
            end
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      ST_OPEN: begin
        if (prog_en) begin
          state_n = ST_PROG;
          idx_n   = '0;
        end else if (timer == '0) begin
          state_n = ST_ENTRY;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      ST_PROG: begin
        if (!prog_en) begin
          state_n = ST_ENTRY;
          idx_n   = '0;
        end else if (key_evt && key_val != 2'd3) begin
          shadow_n = shadow_cand;
          if (idx == LAST) begin
            code_n  = shadow_cand;
            state_n = ST_ENTRY;
            idx_n   = '0;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      ST_ERR: begin
        if (timer == '0) state_n = ST_ENTRY;
        else             timer_n = timer - 32'd1;
      end
      ST_LOCKOUT: begin
        if (timer == '0) begin
          state_n = ST_ENTRY;
          fail_n  = '0;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      default: begin
        state_n = ST_ENTRY;
        idx_n   = '0;
      end
    endcase
  end

  // State registers; outputs are decoded from the next state so they are
  // registered yet change on the same edge as the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ENTRY;
      idx          <= '0;
      entry        <= '0;
      shadow       <= '0;
      code         <= DEFAULT_CODE;
      timer        <= '0;
      fail_cnt     <= '0;
      btn_prev     <= '0;
      leds_verde   <= 8'b0000_0001;
      led_vermelho <= 1'b0;
      unlock       <= 1'b0;
      lockout      <= 1'b0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      entry        <= entry_n;
      shadow       <= shadow_n;
      code         <= code_n;
      timer        <= timer_n;
      fail_cnt     <= fail_n;
      btn_prev     <= btn_pos;
      unlock       <= 1'b0;
      lockout      <= 1'b0;
      led_vermelho <= 1'b0;
      leds_verde   <= '0;
      case (state_n)
        ST_OPEN: begin
          leds_verde <= '1;
          unlock     <= 1'b1;
        end
        ST_PROG:    leds_verde <= 8'h80 | therm({1'b0, idx_n});
        ST_ERR:     led_vermelho <= 1'b1;
        ST_LOCKOUT: begin
          led_vermelho <= 1'b1;
          lockout      <= 1'b1;
        end
        default:    leds_verde <= therm({1'b0, idx_n} + 4'd1);
      endcase
    end
  end

endmodule

// File: tb/tb_safe_access_ctrl.sv
// Bench for safe_access_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a digit-queue model of the safe's rules.
module tb_safe_access_ctrl;

  localparam int unsigned CL = 4;
  localparam int unsigned TO = 10;
  localparam int unsigned TE = 6;
  localparam int unsigned TL = 20;
  localparam int unsigned MF = 3;
  localparam logic [12:0] RST_VEC = 13'b0_0_00_00000001_0;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn;
  logic       prog_en;
  logic       unlock, lockout, led_vermelho;
  logic [1:0] fail_cnt;
  logic [7:0] leds_verde;

  int checks = 0;
  int errors = 0;
  int open_cycles, red_cycles, lock_cycles;

  safe_access_ctrl #(
    .CODE_LEN    (CL),
    .DEFAULT_CODE(8'b10_01_00_00),
    .TIME_OPEN   (TO),
    .TIME_ERR    (TE),
    .TIME_LOCK   (TL),
    .MAX_FAIL    (MF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn         (btn),
    .prog_en     (prog_en),
    .unlock      (unlock),
    .lockout     (lockout),
    .fail_cnt    (fail_cnt),
    .leds_verde  (leds_verde),
    .led_vermelho(led_vermelho)
  );

  always #5 clk = ~clk;

  // Reference model: digits kept as queues, timed modes as remaining cycles.
  typedef enum {M_ENTRY, M_OPEN, M_PROG, M_ERR, M_LOCK} mode_t;
  mode_t      m_mode;
  int         m_entered[$];
  int         m_newcode[$];
  int         m_code[CL];
  int         m_left;
  int         m_fails;
  logic [2:0] m_prev;

  function automatic void model_reset();
    m_mode = M_ENTRY;
    m_entered.delete();
    m_newcode.delete();
    m_code  = '{0, 0, 1, 2};
    m_left  = 0;
    m_fails = 0;
    m_prev  = 3'b000;
  endfunction

  function automatic void model_step(input logic [2:0] b, input logic p);
    logic [2:0] pressed, fresh;
    int n, val;
    bit ok;
    pressed = ~b;
    fresh   = pressed & ~m_prev;
    m_prev  = pressed;
    n       = $countones(fresh);
    val     = 3;
    if (n == 1) for (int k = 0; k < 3; k++) if (fresh[k]) val = k;
    case (m_mode)
      M_ENTRY: if (n > 0) begin
        m_entered.push_back(val);
        if (m_entered.size() == CL) begin
          ok = 1'b1;
          for (int k = 0; k < CL; k++) if (m_entered[k] != m_code[k]) ok = 1'b0;
          m_entered.delete();
          if (ok) begin
            m_mode = M_OPEN; m_left = TO; m_fails = 0;
          end else if (m_fails + 1 == MF) begin
            m_mode = M_LOCK; m_left = TL;
          end else begin
            m_mode = M_ERR; m_left = TE; m_fails++;
          end
        end
      end
      M_OPEN: begin
        if (p) begin
          m_mode = M_PROG;
          m_newcode.delete();
        end else begin
          m_left--;
          if (m_left == 0) m_mode = M_ENTRY;
        end
      end
      M_PROG: begin
        if (!p) m_mode = M_ENTRY;
        else if (n == 1) begin
          m_newcode.push_back(val);
          if (m_newcode.size() == CL) begin
            for (int k = 0; k < CL; k++) m_code[k] = m_newcode[k];
            m_mode = M_ENTRY;
          end
        end
      end
      M_ERR: begin
        m_left--;
        if (m_left == 0) m_mode = M_ENTRY;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_mode  = M_ENTRY;
          m_fails = 0;
        end
      end
    endcase
  endfunction

  // {unlock, lockout, fail_cnt, leds_verde, led_vermelho}
  function automatic logic [12:0] exp_out();
    logic [7:0] g;
    logic u, l, r;
    g = 8'h00; u = 1'b0; l = 1'b0; r = 1'b0;
    case (m_mode)
      M_ENTRY: g = 8'((1 << (m_entered.size() + 1)) - 1);
      M_OPEN:  begin g = 8'hFF; u = 1'b1; end
      M_PROG:  g = 8'h80 | 8'((1 << m_newcode.size()) - 1);
      M_ERR:   r = 1'b1;
      default: begin r = 1'b1; l = 1'b1; end
    endcase
    return {u, l, 2'(m_fails), g, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] b, input logic p);
    btn = b;
    prog_en = p;
    @(posedge clk);
    model_step(b, p);
    #1;
    chk("outputs", {19'd0, unlock, lockout, fail_cnt, leds_verde, led_vermelho}, {19'd0, exp_out()});
    if (unlock) open_cycles++;
    if (led_vermelho && !lockout) red_cycles++;
    if (lockout) lock_cycles++;
  endtask

  task automatic press(input int k, input logic p);
    cyc(~(3'b001 << k), p);
    cyc(3'b111, p);
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d, input logic p);
    press(a, p); press(b, p); press(c, p); press(d, p);
  endtask

  task automatic idle(input int n, input logic p);
    for (int i = 0; i < n; i++) cyc(3'b111, p);
  endtask

  initial begin
    int c0, c1, c2, c3;
    rst = 1'b1; btn = 3'b111; prog_en = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_state", {19'd0, unlock, lockout, fail_cnt, leds_verde, led_vermelho}, {19'd0, RST_VEC});
    rst = 1'b0;

    // 1: default code opens for exactly TIME_OPEN cycles
    open_cycles = 0;
    enter4(0, 0, 1, 2, 1'b0);
    idle(14, 1'b0);
    chk("t1_open_len", open_cycles, TO);
    chk("t1_back_entry", leds_verde, 8'h01);
    chk("t1_fail", fail_cnt, 0);

    // 2: failures, lockout, recovery
    red_cycles = 0;
    enter4(0, 0, 1, 1, 1'b0);
    idle(8, 1'b0);
    chk("t2_err_len", red_cycles, TE);
    chk("t2_fail1", fail_cnt, 1);
    enter4(2, 2, 2, 2, 1'b0);
    idle(8, 1'b0);
    chk("t2_fail2", fail_cnt, 2);
    lock_cycles = 0;
    enter4(0, 0, 0, 0, 1'b0);
    chk("t2_lockout", lockout, 1'b1);
    press(1, 1'b0); press(2, 1'b1);
    idle(20, 1'b0);
    chk("t2_lock_len", lock_cycles, TL);
    chk("t2_fail_clear", fail_cnt, 0);
    chk("t2_presses_ignored", leds_verde, 8'h01);
    enter4(1, 1, 1, 1, 1'b0); idle(8, 1'b0);
    enter4(2, 0, 0, 0, 1'b0); idle(8, 1'b0);
    chk("t2_two_fails", fail_cnt, 2);
    enter4(0, 0, 1, 2, 1'b0);
    chk("t2_open_after_fails", unlock, 1'b1);
    chk("t2_fail_reset", fail_cnt, 0);
    idle(12, 1'b0);

    // 3: reprogram to 2,1,0,0
    enter4(0, 0, 1, 2, 1'b0);
    cyc(3'b111, 1'b1);
    chk("t3_prog_leds", leds_verde, 8'h80);
    enter4(2, 1, 0, 0, 1'b1);
    chk("t3_prog_done", leds_verde, 8'h01);
    idle(2, 1'b0);
    enter4(0, 0, 1, 2, 1'b0);
    chk("t3_old_code_err", led_vermelho, 1'b1);
    idle(8, 1'b0);
    enter4(2, 1, 0, 0, 1'b0);
    chk("t3_new_code_open", unlock, 1'b1);
    idle(12, 1'b0);

    // 4: abort and multi-button in PROG
    enter4(2, 1, 0, 0, 1'b0);
    cyc(3'b111, 1'b1);
    press(0, 1'b1); press(1, 1'b1);
    chk("t4_prog_idx2", leds_verde, 8'h83);
    cyc(3'b111, 1'b0);
    chk("t4_abort", leds_verde, 8'h01);
    idle(2, 1'b0);
    enter4(2, 1, 0, 0, 1'b0);
    chk("t4_code_kept", unlock, 1'b1);
    cyc(3'b111, 1'b1);
    cyc(3'b100, 1'b1);
    cyc(3'b111, 1'b1);
    chk("t4_multi_ignored", leds_verde, 8'h80);
    enter4(0, 0, 1, 2, 1'b1);
    cyc(3'b111, 1'b0);
    chk("t4_restored", leds_verde, 8'h01);

    // 5: multi-button last digit, held button across ERR exit
    press(0, 1'b0); press(0, 1'b0); press(1, 1'b0);
    cyc(3'b010, 1'b0);
    cyc(3'b111, 1'b0);
    chk("t5_multi_err", led_vermelho, 1'b1);
    chk("t5_fail1", fail_cnt, 1);
    for (int i = 0; i < 11; i++) cyc(3'b110, 1'b0);
    chk("t5_held_no_event", leds_verde, 8'h01);
    cyc(3'b111, 1'b0);
    press(0, 1'b0);
    chk("t5_repress", leds_verde, 8'h03);

    // 6: asynchronous reset mid-LOCKOUT and mid-PROG
    press(0, 1'b0); press(0, 1'b0); press(0, 1'b0);
    idle(8, 1'b0);
    enter4(0, 0, 0, 0, 1'b0);
    idle(5, 1'b0);
    chk("t6_in_lockout", lockout, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_lockout", {19'd0, unlock, lockout, fail_cnt, leds_verde, led_vermelho}, {19'd0, RST_VEC});
    model_reset();
    btn = 3'b111; prog_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    enter4(0, 0, 1, 2, 1'b0);
    chk("t6_open", unlock, 1'b1);
    cyc(3'b111, 1'b1);
    press(2, 1'b1); press(1, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_prog", {19'd0, unlock, lockout, fail_cnt, leds_verde, led_vermelho}, {19'd0, RST_VEC});
    model_reset();
    btn = 3'b111; prog_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    enter4(0, 0, 1, 2, 1'b0);
    chk("t6_default_code", unlock, 1'b1);
    idle(12, 1'b0);

    // Random traffic against the model
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 3))
        0: begin
          c0 = m_code[0]; c1 = m_code[1]; c2 = m_code[2]; c3 = m_code[3];
          enter4(c0, c1, c2, c3, 1'b0);
        end
        1: begin
          cyc(3'b111, 1'b1);
          for (int k = 0; k < 4; k++) press(int'($urandom_range(0, 2)), 1'b1);
          cyc(3'b111, 1'b0);
        end
        default: begin
          for (int k = 0; k < 8; k++)
            cyc(($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111,
                ($urandom_range(0, 7) == 0));
        end
      endcase
      if ($urandom_range(0, 4) == 0) idle(22, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/safe_access_ctrl.md
Name: safe_access_ctrl

Overview:
Top-level access controller for the button safe. It collects a full CODE_LEN-digit entry from three active-low buttons, then compares the whole entry against a programmable code register. It drives open, error and lockout timing, counts consecutive failures, and allows re-programming the code only while the safe is open. It sits between the board buttons and switch and the LED and lock outputs.

Parameters:
CODE_LEN, 4, digits per code (1..7)
DEFAULT_CODE, 8'b10_01_00_00, reset code; 2 bits per digit, digit 0 in LSBs, legal digit values 0..2 (width 2*CODE_LEN)
TIME_OPEN, 250_000_000, cycles the safe stays open (5 s at 50 MHz)
TIME_ERR, 150_000_000, cycles in the error display (3 s)
TIME_LOCK, 1_500_000_000, cycles of lockout (30 s)
MAX_FAIL, 3, consecutive failures that trigger lockout (1..3)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
btn  in  3  buttons, active-low, already synchronised; button k = digit k
prog_en  in  1  programming-request switch, active-high
unlock  out  1  lock release, high in OPEN
lockout  out  1  high in LOCKOUT
fail_cnt  out  2  current consecutive-failure count
leds_verde  out  8  green LEDs
led_vermelho  out  1  red LED

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. Reset values:
  - state = ENTRY, idx = 0, entry register = 0, code register = DEFAULT_CODE
  - timer = 0, fail_cnt = 0, btn_prev = 0
  - leds_verde = 8'b00000001, led_vermelho = 0, unlock = 0, lockout = 0
- Edge detect:
  - btn_pos = ~btn; edge = btn_pos & ~btn_prev; btn_prev <= btn_pos every cycle in all states.
  - Key event = any edge bit set. Digit value = index of the set bit if exactly one bit is set. Two or more simultaneous edges give value 3, which never matches any digit.
- Timer: loaded with T-1 when a timed state is entered. It decrements each cycle and the state exits on the cycle the timer is 0, so each timed state lasts exactly T cycles.
- States and transitions:
  - ENTRY: on a key event, store the digit at slot idx, then idx++.
    - When the CODE_LEN-th digit arrives, compare the full entry (including the new digit) with the code register in that same cycle. There is no early abort.
    - Match -> OPEN (timer = TIME_OPEN-1), fail_cnt = 0.
    - Mismatch with fail_cnt+1 == MAX_FAIL -> LOCKOUT (timer = TIME_LOCK-1).
    - Other mismatch -> ERR (timer = TIME_ERR-1), fail_cnt++.
    - idx returns to 0 on any exit from ENTRY.
  - OPEN: key events are ignored. If prog_en = 1 -> PROG with idx = 0, timer held. When the timer reaches 0 -> ENTRY.
  - PROG: each key event with a valid digit (0..2) is written to a shadow register at slot idx, then idx++. Invalid (multi-button) events are ignored.
    - After CODE_LEN digits, code register <= shadow, then -> ENTRY.
    - If prog_en drops before completion, abort: the code is unchanged -> ENTRY.
    - No timeout.
  - ERR: key events are ignored. When the timer reaches 0 -> ENTRY.
  - LOCKOUT: key events and prog_en are ignored. When the timer reaches 0 -> ENTRY and fail_cnt = 0.
  - Illegal state encoding -> ENTRY.
- Outputs (Moore, registered state):
  - ENTRY: leds_verde = thermometer of idx+1 ones.
  - OPEN: leds_verde = 8'hFF, unlock = 1.
  - PROG: leds_verde = 8'h80 | thermometer(idx).
  - ERR: led_vermelho = 1.
  - LOCKOUT: led_vermelho = 1, lockout = 1, leds_verde = 0.
  - fail_cnt is driven directly from its register.
- Buttons already held at reset, or when leaving a timed state, produce no event until they are released and pressed again.
- A reset mid-PROG or mid-LOCKOUT returns everything to reset values, including code = DEFAULT_CODE.

Test Plan:
Use the bench configuration CODE_LEN=4, TIME_OPEN=10, TIME_ERR=6, TIME_LOCK=20, MAX_FAIL=3.
1. Press 0,0,1,2 (matches DEFAULT_CODE) -> leds_verde steps 01, 03, 07, 0F, then OPEN: unlock=1 and leds_verde=FF for exactly 10 cycles, then ENTRY with leds_verde=01 and fail_cnt=0.
2. Enter 0,0,1,1, then 2,2,2,2 -> ERR (led_vermelho=1 for 6 cycles) each time, fail_cnt=1 then 2. Third wrong entry -> lockout=1 for 20 cycles with presses ignored, then fail_cnt=0. Two failures followed by the correct code -> OPEN and fail_cnt=0.
3. Open the safe, raise prog_en, press 2,1,0,0 -> code becomes 8'b00_00_01_10 and the block returns to ENTRY. The old code now goes to ERR; 2,1,0,0 goes to OPEN.
4. In PROG, after 2 digits drop prog_en -> ENTRY with the code unchanged. Press buttons 0+1 in the same cycle during PROG -> ignored, idx unchanged.
5. In ENTRY, press buttons 0+2 in the same cycle as the last digit -> mismatch, ERR. Hold a button across the ERR exit -> no event until it is released and pressed again.
6. Assert rst mid-LOCKOUT and mid-PROG -> all outputs return to reset values immediately (asynchronously), and code = DEFAULT_CODE.
